// File: rtl/zpu_sd_bridge.sv
// zpu_sd_bridge: sector-transfer bridge between the ZPU drive-emulation
// firmware and the hps_io SD block-device interface. Owns the 512-byte
// sector buffer, the LBA register, the per-slot block request FSM and the
// mount-event status reported back to the firmware.
// Build option: define ZPU_SD_WRITE_EN for block-write support; without it
// sd_wr stays 0, block writes are acknowledged at once and readonly reads 1.
module zpu_sd_bridge (
  input  logic        clk_sys,
  input  logic        areset,
  input  logic [5:0]  zpu_out2,
  input  logic [31:0] zpu_out3,
  input  logic        zpu_data_wr,
  input  logic        zpu_data_rd,
  input  logic        zpu_io_wr,
  output logic [7:0]  zpu_in2,
  output logic [31:0] zpu_in3,
  output logic [31:0] sd_lba,
  output logic [2:0]  sd_rd,
  output logic [2:0]  sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  input  logic [2:0]  img_mounted,
  input  logic        img_readonly,
  input  logic [31:0] img_size,
  input  logic [1:0]  ioctl_index_hi
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  // control word fields
  logic       w_lba_sel, w_blk_rd, w_blk_wr;
  logic [1:0] w_slot;
  logic       w_slot_ok;
  logic [2:0] w_slot_oh;

  assign w_lba_sel = zpu_out2[0];
  assign w_blk_rd  = zpu_out2[1];
  assign w_blk_wr  = zpu_out2[2];
  // drives 0/1/4 land on slots 0/1/2; anything mapping to slot 3 is dropped
  assign w_slot    = {zpu_out2[5], zpu_out2[3]};
  assign w_slot_ok = (w_slot != 2'd3);
  assign w_slot_oh = (w_slot == 2'd0) ? 3'b001 :
                     (w_slot == 2'd1) ? 3'b010 : 3'b100;

  // edge-detect and datapath registers
  logic        r_w1, r_w2, r_rd_q, r_blkrd_q, r_blkwr_q, r_ack_q, r_mnt_q;
  logic        r_buf_wr, r_ptr_inc;
  logic [7:0]  r_wdata;
  logic [8:0]  r_ptr;
  logic [31:0] r_lba;
  logic [7:0]  r_q_b, r_q_a;

  logic w_wr_rise, w_rd_fall, w_blkrd_rise, w_blkwr_rise, w_ack_fall, w_mnt_rise;
  assign w_wr_rise    = r_w1 & ~r_w2;
  assign w_rd_fall    = r_rd_q & ~zpu_data_rd;
  assign w_blkrd_rise = w_blk_rd & ~r_blkrd_q;
  assign w_blkwr_rise = w_blk_wr & ~r_blkwr_q;
  assign w_ack_fall   = r_ack_q & ~sd_ack;
  assign w_mnt_rise   = (|img_mounted) & ~r_mnt_q;

  // sector buffer: port A is HPS-side, port B follows the ZPU pointer;
  // both reads registered, ZPU write wins an address collision
  logic [7:0] r_mem [0:511];
  always_ff @(posedge clk_sys) begin
    if (sd_buff_wr) r_mem[sd_buff_addr] <= sd_buff_dout;
    if (r_buf_wr)   r_mem[r_ptr]        <= r_wdata;
    r_q_a <= r_mem[sd_buff_addr];
    r_q_b <= r_mem[r_ptr];
  end

  // ZPU data port: strobe edges, LBA latch, buffer write pulse, pointer
  always_ff @(posedge clk_sys) begin
    if (areset) begin
      r_w1      <= 1'b0;
      r_w2      <= 1'b0;
      r_rd_q    <= 1'b0;
      r_buf_wr  <= 1'b0;
      r_ptr_inc <= 1'b0;
      r_wdata   <= 8'h00;
      r_lba     <= 32'h0;
      r_ptr     <= 9'd0;
    end else begin
      r_w1      <= zpu_data_wr;
      r_w2      <= r_w1;
      r_rd_q    <= zpu_data_rd;
      r_buf_wr  <= w_wr_rise & ~w_lba_sel;
      r_ptr_inc <= r_buf_wr;
      if (w_wr_rise & ~w_lba_sel) r_wdata <= zpu_out3[7:0];
      if (w_wr_rise &  w_lba_sel) r_lba   <= zpu_out3;
      // rewind beats any increment; 9-bit pointer wraps naturally
      if (zpu_io_wr)                   r_ptr <= 9'd0;
      else if (r_ptr_inc | w_rd_fall)  r_ptr <= r_ptr + 9'd1;
    end
  end

  // mount event capture
  logic       r_mounted, r_readonly;
  logic [2:0] r_fileno;
  logic [1:0] r_filetype;
  logic [31:0] r_filesize;
  always_ff @(posedge clk_sys) begin
    if (areset) begin
      r_mnt_q    <= 1'b0;
      r_mounted  <= 1'b0;
      r_readonly <= 1'b0;
      r_fileno   <= 3'd0;
      r_filetype <= 2'd0;
      r_filesize <= 32'h0;
    end else begin
      r_mnt_q <= |img_mounted;
      if (w_mnt_rise) begin
        r_fileno   <= img_mounted[2] ? 3'd4 : (img_mounted[1] ? 3'd1 : 3'd0);
        r_filetype <= ioctl_index_hi;
        r_readonly <= img_readonly | img_mounted[2];
        r_filesize <= img_size;
        r_mounted  <= ~r_mounted;
      end
    end
  end

  // request FSM
  state_t r_state, w_next;
  logic   w_req_rd, w_clr_req, w_done_set, w_nak;
`ifdef ZPU_SD_WRITE_EN
  logic   w_req_wr;
`endif

  // FSM state register
  always_ff @(posedge clk_sys) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state and request/done strobes; read wins a simultaneous edge
  always_comb begin
    w_next     = r_state;
    w_req_rd   = 1'b0;
    w_clr_req  = 1'b0;
    w_done_set = 1'b0;
    w_nak      = 1'b0;
`ifdef ZPU_SD_WRITE_EN
    w_req_wr   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_slot_ok) begin
          if (w_blkrd_rise) begin
            w_next   = S_REQ;
            w_req_rd = 1'b1;
          end else if (w_blkwr_rise) begin
`ifdef ZPU_SD_WRITE_EN
            w_next   = S_REQ;
            w_req_wr = 1'b1;
`else
            w_nak    = 1'b1;
`endif
          end
        end
      end
      S_REQ: begin
        if (sd_ack) begin
          w_next    = S_XFER;
          w_clr_req = 1'b1;
        end
      end
      S_XFER: begin
        if (w_ack_fall) begin
          w_next     = S_IDLE;
          w_done_set = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // request bits, io_done and handshake edge flops
  logic [2:0] r_sd_rd;
  logic       r_io_done, r_nak_q;
`ifdef ZPU_SD_WRITE_EN
  logic [2:0] r_sd_wr;
`endif
  always_ff @(posedge clk_sys) begin
    if (areset) begin
      r_sd_rd   <= 3'b000;
`ifdef ZPU_SD_WRITE_EN
      r_sd_wr   <= 3'b000;
`endif
      r_io_done <= 1'b1;
      r_nak_q   <= 1'b0;
      r_blkrd_q <= 1'b0;
      r_blkwr_q <= 1'b0;
      r_ack_q   <= 1'b0;
    end else begin
      r_blkrd_q <= w_blk_rd;
      r_blkwr_q <= w_blk_wr;
      r_ack_q   <= sd_ack;
      r_nak_q   <= w_nak;
      if (w_done_set | r_nak_q) r_io_done <= 1'b1;
      if (w_clr_req) begin
        r_sd_rd <= 3'b000;
`ifdef ZPU_SD_WRITE_EN
        r_sd_wr <= 3'b000;
`endif
      end
      if (w_req_rd) begin
        r_sd_rd   <= w_slot_oh;
        r_io_done <= 1'b0;
      end
`ifdef ZPU_SD_WRITE_EN
      if (w_req_wr) begin
        r_sd_wr   <= w_slot_oh;
        r_io_done <= 1'b0;
      end
`endif
      // unsupported write: drop io_done for one cycle so firmware moves on
      if (w_nak) r_io_done <= 1'b0;
    end
  end

  logic w_ro;
`ifdef ZPU_SD_WRITE_EN
  assign sd_wr = r_sd_wr;
  assign w_ro  = r_readonly;
`else
  assign sd_wr = 3'b000;
  // every image is read-only when writes cannot be serviced
  assign w_ro  = r_readonly | 1'b1;
`endif

  assign sd_rd       = r_sd_rd;
  assign sd_lba      = r_lba;
  assign sd_buff_din = r_q_a;
  assign zpu_in2     = {w_ro, r_filetype, r_fileno, r_mounted, r_io_done};
  assign zpu_in3     = w_lba_sel ? r_filesize : {24'h0, r_q_b};

endmodule

// File: doc/zpu_sd_bridge.md
# zpu_sd_bridge

Sector-transfer bridge between the ZPU drive-emulation firmware (ZPU_IN2/IN3, ZPU_OUT2/OUT3, ZPU_RD/WR strobes) and the hps_io SD block-device interface. It owns the 512-byte sector buffer and the LBA register, and issues per-drive block read/write requests. It also reports mount events (slot, file type, read-only flag, size) to the firmware. It sits directly between hps_io and atari800top, replacing the inline glue in the emu top level.

## Interface
- Parameters: none.
- clk_sys  in  1  system clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- zpu_out2  in  6  [0] lba_sel (IN3 mux / OUT3 target); [1] block_rd; [2] block_wr; [5:3] drv_num.
- zpu_out3  in  32  ZPU data word; only [7:0] is used for buffer data.
- zpu_data_wr  in  1  ZPU write strobe for the data port (ZPU_WR[6]).
- zpu_data_rd  in  1  ZPU read strobe for the data port (ZPU_RD[2]).
- zpu_io_wr  in  1  ZPU control write (ZPU_WR[5]); rewinds the buffer pointer.
- zpu_in2  out  8  {readonly, filetype[1:0], fileno[2:0], mounted, io_done}.
- zpu_in3  out  32  lba_sel ? filesize : {24'h0, buffer byte at pointer}.
- sd_lba  out  32  LBA presented to hps_io.
- sd_rd, sd_wr  out  3  per-slot request bits, one-hot.
- sd_ack  in  1  hps_io transfer acknowledge.
- sd_buff_addr  in  9  HPS-side buffer address.
- sd_buff_dout  in  8  HPS-side buffer write data.
- sd_buff_wr  in  1  HPS-side buffer write enable.
- sd_buff_din  out  8  HPS-side buffer read data, 1-cycle latency.
- img_mounted  in  3  per-slot mount pulse.
- img_readonly  in  1  read-only flag of the mounted image.
- img_size  in  32  image size in bytes (low 32 bits).
- ioctl_index_hi  in  2  ioctl_index[7:6], latched as the file type.

## Operation
- Buffer: 512x8 true dual-port RAM. Port A is HPS-side. Port B is ZPU-side, addressed by the 9-bit pointer `ptr`. Both ports have a registered read.
- ZPU write path:
  - zpu_data_wr is delayed through two flops, w1 then w2. A rise is detected when w1 & ~w2.
  - On a rise with lba_sel=1: sd_lba <= zpu_out3.
  - On a rise with lba_sel=0: a one-cycle buf_wr pulse writes zpu_out3[7:0] at ptr. ptr increments in the cycle after buf_wr.
- ZPU read path: on the falling edge of zpu_data_rd (registered previous value 1, current value 0), ptr <= ptr+1.
- Pointer: zpu_io_wr=1 forces ptr <= 0. This has priority over every increment in the same cycle. ptr wraps 511 -> 0.
- Slot map: slot = {drv_num[2], drv_num[0]}. Drive 0 maps to slot 0, drive 1 to slot 1, drive 4 to slot 2. Slot 3 requests are dropped; no sd bit is set and io_done is unchanged.
- Request FSM:
  - IDLE -> REQ on a rising edge of block_rd or block_wr. sd_rd[slot] or sd_wr[slot] <= 1, and io_done <= 0. If both edges occur in the same cycle, the read wins.
  - REQ -> XFER when sd_ack=1. All sd_rd/sd_wr bits are cleared that cycle.
  - XFER -> IDLE on a falling edge of sd_ack; io_done <= 1.
  - Edges of block_rd/block_wr outside IDLE are ignored.
- Mount: on a rising edge of |img_mounted:
  - fileno <= 0, 1 or 4 for slots 0, 1, 2. If several bits are set, the highest slot wins.
  - filetype <= ioctl_index_hi.
  - readonly <= img_readonly | img_mounted[2].
  - filesize <= img_size.
  - mounted toggles.

## Timing
- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, ptr=0, io_done=1, mounted=0, fileno=0, filetype=0, readonly=0, filesize=0, FSM=IDLE, all edge-detect flops=0. zpu_in3 follows the mux; buffer contents are not cleared.
- areset during REQ or XFER aborts the transfer: requests drop in the same cycle and the FSM returns to IDLE with io_done=1. A late sd_ack falling edge after the abort has no effect.
- Buffer write lands 3 clk_sys edges after zpu_data_wr is first sampled high; ptr increments on the 4th edge.
- zpu_in3 byte is valid 1 cycle after ptr changes.
- Request bits assert 1 cycle after the block_rd/block_wr edge is sampled.
- io_done rises 1 cycle after sd_ack is sampled low.

## Configuration
- ZPU_SD_WRITE_EN defined: full write support as described.
- ZPU_SD_WRITE_EN undefined:
  - sd_wr is tied to 0.
  - A block_wr edge in IDLE leaves the FSM in IDLE and pulses io_done 0 then 1 over two cycles, so firmware does not hang.
  - The readonly output is forced to 1.

## Test plan
- Reset, then lba_sel=1, zpu_out3=0x00001234, one data_wr pulse -> sd_lba=0x1234 after 3 edges; ptr stays 0.
- Mount with img_mounted=3'b100, img_size=92176, img_readonly=0 -> zpu_in2: mounted=1, fileno=4, readonly=1; with lba_sel=1, zpu_in3=92176.
- block_rd edge with drv_num=1 -> sd_rd=3'b010 and io_done=0. Apply sd_ack high for 5 cycles -> sd_rd=0. On sd_ack low -> io_done=1 one cycle later.
- HPS writes 0xA5 at address 0 and 0x5A at address 1. ZPU pulses io_wr, then reads with two data_rd pulses -> zpu_in3 reads 0xA5 then 0x5A; ptr=2.
- 512 ZPU data writes of value i&0xFF after io_wr -> ptr wraps to 0; HPS reading address 511 returns 0xFF.
- block_wr edge with drv_num=0, then areset asserted while in REQ -> sd_wr=0 and io_done=1 immediately. Without ZPU_SD_WRITE_EN: sd_wr never asserts and io_done pulses 0 then 1.
